rx_packet_queue: RTL and testbench
==================================

Name: rx_packet_queue

Overview:
Sits directly downstream of spi_interface and consumes its receive-side outputs (RX_valid pulse plus packet_meta_data, packet_prefix, packet_data). Captures each received packet into a small FIFO, decodes the packet type from the metadata byte, and presents packets to the router core over a valid/ready handshake. This decouples the single-cycle RX_valid pulse from router back-pressure, and counts packets dropped on overflow.

Parameters:
DEPTH, 4, number of packet entries; power of two, at least 2
PTR_W, 2, log2(DEPTH); width of the read and write pointers

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous reset, active-low (asserted when 0)
RX_valid  input  1  one-cycle pulse from spi_interface; packet fields are valid in that cycle
packet_meta_data  input  8  [7:6] type (00 interest, 01 data, 10/11 reserved); [5:0] payload length in bytes
packet_prefix  input  64  name prefix
packet_data  input  256  payload
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts head entry
out_meta_data  output  8  head metadata
out_prefix  output  64  head prefix
out_data  output  256  head payload
out_is_data  output  1  head type == 01
count  output  PTR_W+1  entries currently held, 0..DEPTH
overflow  output  1  one-cycle pulse when an accepted packet is lost because the FIFO is full
drop_count  output  8  saturating count of dropped packets

Behaviour:
- Reset (rst==0 at posedge): wr_ptr, rd_ptr, count, overflow, and drop_count go to 0. Storage array is not reset. Reset wins over any same-cycle push or pop. A reset mid-stream discards all entries.
- Push condition: RX_valid==1 and the packet is accepted (see Optional Feature) and (count<DEPTH or pop in the same cycle).
- On push: write all three fields at wr_ptr; wr_ptr increments modulo DEPTH (natural PTR_W-bit wrap).
- Pop condition: out_valid && out_ready. On pop, rd_ptr increments modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on push+pop.
- Simultaneous push and pop at full: both occur, and count stays DEPTH. This is not an overflow.
- Simultaneous push and pop at empty: impossible, because out_valid is 0. Push occurs, and count becomes 1.
- Full with RX_valid, accepted packet, and no pop: packet discarded. overflow=1 in the next cycle for exactly one cycle. drop_count increments, saturating at 255.
- out_valid = (count!=0), combinational from the count register. The head fields are read combinationally from the array at rd_ptr (show-ahead).
- When count==0: out_meta_data, out_prefix, and out_data are forced to 0, and out_is_data is 0.
- Latency: a packet pushed at edge N is visible at the outputs after edge N (out_valid high in cycle N+1 if the FIFO was empty).
- out_is_data = (out_meta_data[7:6]==2'b01).
- Order: strict FIFO; no reordering by type.
- The consumer may hold out_ready high continuously. Head outputs must remain stable while out_valid && !out_ready.

Optional Feature:
Macro RX_PKT_FILTER_EN.
- Defined: a packet is accepted only if meta[7:6] is 00 or 01 and meta[5:0] <= 32. Rejected packets are not stored, do not pulse overflow, but do increment drop_count (saturating).
- Undefined: every RX_valid packet is accepted regardless of metadata. drop_count counts overflow losses only.

Test Plan:
1. Reset with rst=0 for 2 cycles, then rst=1 -> count=0, out_valid=0, all out_* fields 0, overflow=0, drop_count=0.
2. Single push: meta=8'h0C, prefix=64'd129, data="here is data", out_ready=0 -> next cycle out_valid=1, count=1, out_prefix=129, out_is_data=0. Outputs stay stable for 5 cycles. Then out_ready=1 for 1 cycle -> count=0, out_valid=0.
3. Fill and overflow (DEPTH=4): 5 pushes with prefixes 1..5, out_ready=0 -> count=4, one overflow pulse after the 5th, drop_count=1. Drain returns prefixes 1,2,3,4 in order.
4. Full with simultaneous push+pop: after filling with 1..4, push prefix 9 while out_ready=1 -> no overflow, count=4. Drain order is 2,3,4,9.
5. Type and filter: push meta=8'h48 (data, len 8) -> out_is_data=1. Push meta=8'h80 -> with RX_PKT_FILTER_EN: not stored, drop_count+1, overflow=0. Without it: stored, count increments.
6. Saturation and wrap: 300 overflowing pushes -> drop_count holds at 255. Reset asserted with count=3 -> count=0 next cycle, and pointers wrap correctly over 10 subsequent push/pop cycles.

Source files
------------

// File: rtl/rx_packet_queue_if.sv
// Packet payload type and the RX/consumer-facing bus of rx_packet_queue.
// slave modport is the queue side; master modport is the producer/consumer side.
package rx_packet_queue_pkg;
  localparam int unsigned META_W   = 8;
  localparam int unsigned PREFIX_W = 64;
  localparam int unsigned DATA_W   = 256;

  typedef struct packed {
    logic [META_W-1:0]   meta;
    logic [PREFIX_W-1:0] prefix;
    logic [DATA_W-1:0]   data;
  } rx_pkt_t;
endpackage

interface rx_packet_queue_if;
  import rx_packet_queue_pkg::*;

  logic                RX_valid;
  logic [META_W-1:0]   packet_meta_data;
  logic [PREFIX_W-1:0] packet_prefix;
  logic [DATA_W-1:0]   packet_data;
  logic                out_valid;
  logic                out_ready;
  logic [META_W-1:0]   out_meta_data;
  logic [PREFIX_W-1:0] out_prefix;
  logic [DATA_W-1:0]   out_data;
  logic                out_is_data;

  modport slave (
    input  RX_valid, packet_meta_data, packet_prefix, packet_data, out_ready,
    output out_valid, out_meta_data, out_prefix, out_data, out_is_data
  );

  modport master (
    output RX_valid, packet_meta_data, packet_prefix, packet_data, out_ready,
    input  out_valid, out_meta_data, out_prefix, out_data, out_is_data
  );
endinterface

// File: rtl/rx_packet_queue.sv
// Show-ahead packet FIFO between spi_interface RX and the router core, with overflow drop count.
// Optional metadata filter enabled by defining RX_PKT_FILTER_EN.
module rx_packet_queue
  import rx_packet_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  rx_packet_queue_if.slave bus,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic [7:0]       drop_count
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  rx_pkt_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_count_q, drop_count_d;

  logic    accept_c, full_c, push_c, pop_c, drop_c;
  rx_pkt_t wr_pkt_c, head_c;

  // Acceptance filter on packet type and length
  always_comb begin
`ifdef RX_PKT_FILTER_EN
    accept_c = (bus.packet_meta_data[7] == 1'b0) && (bus.packet_meta_data[5:0] <= 6'd32);
`else
    accept_c = 1'b1;
`endif
  end

  always_comb begin
    wr_pkt_c      = '0;
    full_c        = (count_q == DEPTH_C);
    pop_c         = (count_q != '0) && bus.out_ready;
    push_c        = bus.RX_valid && accept_c && (!full_c || pop_c);
    overflow_d    = bus.RX_valid && accept_c && full_c && !pop_c;
    drop_c        = overflow_d || (bus.RX_valid && !accept_c);
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    drop_count_d  = drop_count_q;

    wr_pkt_c.meta   = bus.packet_meta_data;
    wr_pkt_c.prefix = bus.packet_prefix;
    wr_pkt_c.data   = bus.packet_data;

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_c && !pop_c)      count_d = count_q + (PTR_W+1)'(1);
    else if (pop_c && !push_c) count_d = count_q - (PTR_W+1)'(1);
    if (drop_c && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Storage is deliberately unreset; reset still blocks the write
  always_ff @(posedge clk) begin
    if (rst && push_c) mem_q[wr_ptr_q] <= wr_pkt_c;
  end

  // Show-ahead head, zeroed while empty
  always_comb begin
    head_c = mem_q[rd_ptr_q];
    if (count_q == '0) head_c = '0;
    bus.out_valid     = (count_q != '0);
    bus.out_meta_data = head_c.meta;
    bus.out_prefix    = head_c.prefix;
    bus.out_data      = head_c.data;
    bus.out_is_data   = (head_c.meta[7:6] == 2'b01);
  end

  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_rx_packet_queue.sv
// Scoreboard bench for rx_packet_queue: accepted packets queue up as expectations,
// consumed in order as the DUT pops them.
module tb_rx_packet_queue;
  import rx_packet_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [PTR_W:0] count;
  logic           overflow;
  logic [7:0]     drop_count;

  rx_packet_queue_if bus ();

  rx_packet_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .count      (count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int      n_checks = 0;
  int      n_errors = 0;
  rx_pkt_t sb[$];
  int      exp_drop = 0;
  logic [255:0] here_data;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit accepted(input logic [7:0] m);
`ifdef RX_PKT_FILTER_EN
    return (m[7:6] == 2'b00 || m[7:6] == 2'b01) && (int'(m[5:0]) <= 32);
`else
    return 1'b1;
`endif
  endfunction

  // Compare all outputs against the scoreboard state after an edge
  task automatic check_outputs(input bit exp_ovf);
    rx_pkt_t h;
    h = (sb.size() != 0) ? sb[0] : '0;
    check("count", 256'(count), 256'(sb.size()));
    check("out_valid", 256'(bus.out_valid), 256'(sb.size() != 0));
    check("overflow", 256'(overflow), 256'(exp_ovf));
    check("drop_count", 256'(drop_count), 256'(exp_drop));
    check("out_meta", 256'(bus.out_meta_data), 256'(h.meta));
    check("out_prefix", 256'(bus.out_prefix), 256'(h.prefix));
    check("out_data", bus.out_data, h.data);
    check("out_is_data", 256'(bus.out_is_data), 256'(h.meta[7:6] == 2'b01));
  endtask

  // One clock: drive inputs, update the scoreboard, then check after the edge
  task automatic cycle(input bit v, input logic [7:0] m, input logic [63:0] p,
                       input logic [255:0] d, input bit rdy);
    bit full, pop, acc, ovf;
    rx_pkt_t pkt;
    bus.RX_valid         = v;
    bus.packet_meta_data = m;
    bus.packet_prefix    = p;
    bus.packet_data      = d;
    bus.out_ready        = rdy;
    full = (sb.size() == DEPTH);
    pop  = (sb.size() != 0) && rdy;
    acc  = accepted(m);
    ovf  = v && acc && full && !pop;
    if (pop) void'(sb.pop_front());
    if (v && acc && !ovf) begin
      pkt.meta = m; pkt.prefix = p; pkt.data = d;
      sb.push_back(pkt);
    end
    if ((ovf || (v && !acc)) && exp_drop < 255) exp_drop++;
    @(posedge clk);
    #1;
    check_outputs(ovf);
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 8'h00, 64'd0, 256'd0, rdy);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    bus.RX_valid = 1'b1;   // reset must win over a concurrent push
    bus.packet_meta_data = 8'h01;
    bus.packet_prefix = 64'hDEAD;
    bus.packet_data = 256'd7;
    bus.out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    exp_drop = 0;
    bus.RX_valid = 1'b0;
    bus.out_ready = 1'b0;
    check_outputs(1'b0);
  endtask

  initial begin
    bus.RX_valid = 1'b0;
    bus.packet_meta_data = '0;
    bus.packet_prefix = '0;
    bus.packet_data = '0;
    bus.out_ready = 1'b0;
    here_data = "here is data";

    // 1: reset
    do_reset(2);

    // 2: single push, hold stable, then pop
    cycle(1'b1, 8'h0C, 64'd129, here_data, 1'b0);
    check("prefix_129", 256'(bus.out_prefix), 256'(129));
    repeat (5) idle(1'b0);
    idle(1'b1);

    // 3: fill and overflow, then drain
    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'h04, 64'(i), 256'(i * 3), 1'b0);
    idle(1'b0);
    repeat (4) idle(1'b1);

    // 4: push+pop at full
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'h44, 64'(i), 256'(i), 1'b0);
    cycle(1'b1, 8'h44, 64'd9, 256'd9, 1'b1);
    repeat (4) idle(1'b1);

    // 5: type decode and filter
    cycle(1'b1, 8'h48, 64'd50, 256'd50, 1'b0);
    check("is_data_48", 256'(bus.out_is_data), 256'(1));
    cycle(1'b1, 8'h80, 64'd51, 256'd51, 1'b0);
    cycle(1'b1, 8'h21, 64'd52, 256'd52, 1'b0);   // interest, len 33
    repeat (3) idle(1'b1);

    // 6: drop_count saturation
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h01, 64'(100 + i), 256'(i), 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b1, 8'h02, 64'(200 + i), 256'(i), 1'b0);
    check("drop_sat", 256'(drop_count), 256'(255));
    idle(1'b1);
    do_reset(1);

    // pointer wrap after mid-stream reset
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 8'(8'h40 | 8'(i)), 64'(300 + i), 256'($urandom), (i % 3) != 0);
    for (int i = 0; i < 12; i++)
      cycle(($urandom_range(0, 1) == 1), 8'h05, 64'(400 + i), 256'($urandom),
            ($urandom_range(0, 1) == 1));
    repeat (5) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
